// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The controller takes the slave view; the datapath (or a bench) takes the master view.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       instr_done;
    logic       trap;

    modport slave (
        input  opcode, funct3, funct7, zero, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, trap
    );

    modport master (
        output opcode, funct3, funct7, zero, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, trap
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-ALU, unified-memory multicycle RV32I datapath.
// Controls are decoded from the state register; only memory/branch enables look at inputs.
module multicycle_controller #(
    parameter int ST_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.slave bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    typedef enum logic [ST_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK, S_LUI, S_TRAP
    } state_t;

    state_t     r_state;
    state_t     w_decode_next;
    logic       w_f3_shift;
    logic       w_r_legal;
    logic       w_i_legal;
    logic       w_b_legal;
    logic       w_sub;
    logic       w_br_take;
    logic [2:0] w_arith_op;
    logic [2:0] w_br_op;
    logic [2:0] w_imm_src;

    // Shift encodings (funct3 001/101) lie outside the supported subset and trap in R and I forms.
    assign w_f3_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
    assign w_r_legal  = !w_f3_shift &&
                        ((bus.funct7 == 7'h00) || ((bus.funct7 == 7'h20) && (bus.funct3 == 3'b000)));
    assign w_i_legal  = !w_f3_shift;
    assign w_b_legal  = !bus.funct3[1];
    assign w_sub      = (r_state == S_EXECR) && bus.funct7[5];
    assign w_br_op    = bus.funct3[2] ? (bus.funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
    // beq/bge/bgeu take on zero, the inverted forms on ~zero.
    assign w_br_take  = bus.zero ^ (bus.funct3[0] ^ bus.funct3[2]);

    always_comb begin
        unique case (bus.funct3)
            3'b000:  w_arith_op = w_sub ? ALU_SUB : ALU_ADD;
            3'b010:  w_arith_op = ALU_SLT;
            3'b011:  w_arith_op = ALU_SLTU;
            3'b100:  w_arith_op = ALU_XOR;
            3'b110:  w_arith_op = ALU_OR;
            3'b111:  w_arith_op = ALU_AND;
            default: w_arith_op = ALU_ADD;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OP_STORE: w_imm_src = 3'b001;
            OP_BR:    w_imm_src = 3'b010;
            OP_JAL:   w_imm_src = 3'b011;
            OP_LUI:   w_imm_src = 3'b100;
            default:  w_imm_src = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OP_LOAD, OP_STORE: w_decode_next = S_MEMADR;
            OP_R:              w_decode_next = w_r_legal ? S_EXECR  : S_TRAP;
            OP_I:              w_decode_next = w_i_legal ? S_EXECI  : S_TRAP;
            OP_BR:             w_decode_next = w_b_legal ? S_BRANCH : S_TRAP;
            OP_JAL:            w_decode_next = S_JAL;
            OP_JALR:           w_decode_next = S_JALR;
            OP_LUI:            w_decode_next = S_LUI;
            default:           w_decode_next = S_TRAP;
        endcase
    end

    // NOTE: state is a flop, so it is only ever written with <= in a clocked block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:     r_state <= bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE:    r_state <= w_decode_next;
                S_MEMADR:    r_state <= (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:   r_state <= bus.mem_ready ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE:  r_state <= bus.mem_ready ? S_FETCH : S_MEMWRITE;
                S_EXECR,
                S_EXECI,
                S_JAL:       r_state <= S_ALUWB;
                S_JALR:      r_state <= S_JALR_LINK;
                S_TRAP:      r_state <= S_TRAP;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned.
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.ImmSrc     = 3'b000;
        bus.instr_done = 1'b0;
        bus.trap       = 1'b0;
        if (rst) begin
            bus.ImmSrc = w_imm_src;
            case (r_state)
                S_FETCH: begin
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                    bus.IRWrite   = bus.mem_ready;
                    bus.PCWrite   = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 2'b10;
                    bus.ALUSrcB = 2'b01;
                end
                S_MEMREAD:  bus.AdrSrc = 1'b1;
                S_MEMWB: begin
                    bus.ResultSrc  = 2'b01;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.AdrSrc     = 1'b1;
                    bus.MemWrite   = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXECR, S_EXECI: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                    bus.ALUControl = w_arith_op;
                end
                S_ALUWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUControl = w_br_op;
                    bus.PCWrite    = w_br_take;
                    bus.instr_done = 1'b1;
                end
                S_JAL: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                    bus.PCWrite = 1'b1;
                end
                S_JALR: begin
                    bus.ALUSrcA   = 2'b10;
                    bus.ALUSrcB   = 2'b01;
                    bus.ResultSrc = 2'b10;
                    bus.PCWrite   = 1'b1;
                end
                S_JALR_LINK: begin
                    bus.ALUSrcA    = 2'b01;
                    bus.ALUSrcB    = 2'b10;
                    bus.ResultSrc  = 2'b10;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_LUI: begin
                    bus.ResultSrc  = 2'b11;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_TRAP:  bus.trap = 1'b1;
                default: bus.ImmSrc = w_imm_src;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expectations from an ISA-level
// model are queued by the driver and compared by a monitor at every instr_done pulse.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [2:0] NO_RS1   = 3'b111;

    typedef struct {
        int         lat;
        int         n_rw;
        int         n_pw;
        int         n_mw;
        int         n_ir;
        logic [2:0] rs1_op;
        logic [1:0] wb_src;
        logic [3:0] wb_ab;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if ifc();
    multicycle_controller #(.ST_W(4)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    int         a_cyc, a_rw, a_pw, a_mw, a_ir;
    logic [2:0] a_rs1_op;
    logic [1:0] a_wb_src;
    logic [3:0] a_wb_ab;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [18:0] outs();
        return {ifc.PCWrite, ifc.AdrSrc, ifc.IRWrite, ifc.MemWrite, ifc.RegWrite, ifc.ResultSrc,
                ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUControl, ifc.ImmSrc, ifc.instr_done, ifc.trap};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == OP_STORE) return 3'b001;
        if (op == OP_BR)    return 3'b010;
        if (op == OP_JAL)   return 3'b011;
        if (op == OP_LUI)   return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit valid_op(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    endfunction

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (!valid_op(op)) return 1'b0;
        if ((op == OP_R || op == OP_I) && (f3 == 3'd1 || f3 == 3'd5)) return 1'b0;
        if (op == OP_R && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0))) return 1'b0;
        if (op == OP_BR && !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5})) return 1'b0;
        return 1'b1;
    endfunction

    // Operation the ALU applies to rs1 for an R/I arithmetic instruction.
    function automatic logic [2:0] arith(input logic [2:0] f3, input bit is_sub);
        case (f3)
            3'd0:    return is_sub ? 3'b001 : 3'b000;
            3'd2:    return 3'b100;
            3'd3:    return 3'b110;
            3'd4:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Instruction-level expectation: cycles to done, enable counts, rs1 ALU op, writeback source.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic z, input int f, input int m);
        exp_t e;
        bit   taken;
        e = '{lat: 0, n_rw: 0, n_pw: 1, n_mw: 0, n_ir: 1, rs1_op: NO_RS1, wb_src: 2'b00, wb_ab: 4'h0};
        case (op)
            OP_LOAD:  begin e.lat = 5 + m; e.n_rw = 1; e.rs1_op = 3'b000; e.wb_src = 2'b01; end
            OP_STORE: begin e.lat = 4 + m; e.n_mw = m + 1; e.rs1_op = 3'b000; end
            OP_R:     begin e.lat = 4; e.n_rw = 1; e.rs1_op = arith(f3, f7 == 7'h20); end
            OP_I:     begin e.lat = 4; e.n_rw = 1; e.rs1_op = arith(f3, 1'b0); end
            OP_BR: begin
                e.lat    = 3;
                e.rs1_op = f3[2] ? 3'b100 : 3'b001;
                case (f3)
                    3'd0:    taken = z;     // beq: equal when difference is zero
                    3'd1:    taken = !z;    // bne
                    3'd4:    taken = !z;    // blt: slt result nonzero
                    default: taken = z;     // bge
                endcase
                e.n_pw += int'(taken);
            end
            OP_JAL:   begin e.lat = 4; e.n_rw = 1; e.n_pw = 2; end
            OP_JALR:  begin e.lat = 4; e.n_rw = 1; e.n_pw = 2; e.rs1_op = 3'b000;
                            e.wb_src = 2'b10; e.wb_ab = 4'b0110; end
            default:  begin e.lat = 3; e.n_rw = 1; e.wb_src = 2'b11; end
        endcase
        e.lat += f;
        return e;
    endfunction

    function automatic void clear_acc();
        a_cyc = 0; a_rw = 0; a_pw = 0; a_mw = 0; a_ir = 0;
        a_rs1_op = NO_RS1; a_wb_src = 2'b00; a_wb_ab = 4'h0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            clear_acc();
        end else begin
            a_cyc++;
            if (ifc.RegWrite) begin
                a_rw++;
                a_wb_src = ifc.ResultSrc;
                a_wb_ab  = {ifc.ALUSrcA, ifc.ALUSrcB};
            end
            if (ifc.PCWrite)  a_pw++;
            if (ifc.MemWrite) a_mw++;
            if (ifc.IRWrite)  a_ir++;
            if (ifc.ALUSrcA == 2'b10) a_rs1_op = ifc.ALUControl;
            check("immsrc", ifc.ImmSrc, imm_of(ifc.opcode));
            if (ifc.instr_done) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", ifc.instr_done, 1'b0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("latency",    a_cyc,    mon_e.lat);
                    check("regwrites",  a_rw,     mon_e.n_rw);
                    check("pcwrites",   a_pw,     mon_e.n_pw);
                    check("memwrites",  a_mw,     mon_e.n_mw);
                    check("irwrites",   a_ir,     mon_e.n_ir);
                    check("rs1_aluop",  a_rs1_op, mon_e.rs1_op);
                    check("wb_src",     a_wb_src, mon_e.wb_src);
                    check("wb_alusrc",  a_wb_ab,  mon_e.wb_ab);
                end
                clear_acc();
            end
        end
    end

    // Leaves the DUT out of reset with time just after a rising edge and the FSM in fetch.
    task automatic do_reset();
        rst = 1'b0;
        ifc.mem_ready = 1'b1;
        #2;
        check("reset_outputs", outs(), 19'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_held", outs(), 19'h0);
        @(posedge clk);
        #1;
        sb_q.delete();
        rst = 1'b1;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic z);
        ifc.opcode = op;
        ifc.funct3 = f3;
        ifc.funct7 = f7;
        ifc.zero   = z;
    endtask

    // f = fetch stall cycles, m = data-memory stall cycles (loads/stores only).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input int f, input int m);
        bit   mr[$];
        bit   done;
        bit   legal;
        bit   is_mem;
        exp_t e;
        legal  = is_legal(op, f3, f7);
        is_mem = legal && (op == OP_LOAD || op == OP_STORE);
        set_fields(op, f3, f7, z);
        for (int i = 0; i < f; i++) mr.push_back(1'b0);
        mr.push_back(1'b1);
        if (is_mem) begin
            mr.push_back(1'($urandom_range(0, 1)));
            mr.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < m; i++) mr.push_back(1'b0);
            mr.push_back(1'b1);
        end
        if (legal) begin
            e = model(op, f3, f7, z, f, is_mem ? m : 0);
            sb_q.push_back(e);
            done = 1'b0;
            for (int c = 0; c < e.lat + 20; c++) begin
                ifc.mem_ready = (c < mr.size()) ? mr[c] : 1'($urandom_range(0, 1));
                @(negedge clk);
                done = ifc.instr_done;
                @(posedge clk);
                #1;
                if (done) break;
            end
            if (!done) begin
                check("done_timeout", done, 1'b1);
                do_reset();
            end
        end else begin
            for (int c = 0; c < f + 2; c++) begin
                ifc.mem_ready = mr[c];
                @(posedge clk);
                #1;
            end
            for (int t = 0; t < 20; t++) begin
                ifc.mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("trap_flag", ifc.trap, 1'b1);
                check("trap_quiet", {ifc.PCWrite, ifc.IRWrite, ifc.MemWrite, ifc.RegWrite,
                                     ifc.instr_done}, 5'h0);
                @(posedge clk);
                #1;
            end
            do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit hit, got no summary, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [6:0] op;
        logic [6:0] f7;
        logic [6:0] ops [8];
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
        set_fields(7'h0, 3'h0, 7'h0, 1'b0);
        ifc.mem_ready = 1'b1;
        #1;
        do_reset();

        run_instr(OP_R,    3'd0, 7'h00, 1'b0, 0, 0);   // add x3,x1,x2
        run_instr(OP_LOAD, 3'd2, 7'h00, 1'b0, 0, 3);   // lw, three memory stalls
        run_instr(OP_BR,   3'd0, 7'h00, 1'b1, 0, 0);   // beq taken
        run_instr(OP_BR,   3'd0, 7'h00, 1'b0, 0, 0);   // beq not taken
        run_instr(OP_BR,   3'd5, 7'h00, 1'b1, 0, 0);   // bge taken
        run_instr(OP_BR,   3'd5, 7'h00, 1'b0, 1, 0);   // bge not taken, fetch stall
        run_instr(OP_JALR, 3'd0, 7'h00, 1'b0, 0, 0);
        run_instr(OP_JAL,  3'd0, 7'h00, 1'b0, 0, 0);
        run_instr(OP_LUI,  3'd0, 7'h00, 1'b0, 0, 0);
        run_instr(OP_STORE, 3'd2, 7'h00, 1'b0, 2, 2);
        run_instr(OP_R,    3'd0, 7'h20, 1'b0, 0, 0);   // sub
        run_instr(7'h7F,   3'd0, 7'h00, 1'b0, 0, 0);   // unknown opcode
        run_instr(OP_I,    3'd1, 7'h00, 1'b0, 0, 0);   // slli is unsupported

        // Store aborted by reset while its write is stalled.
        set_fields(OP_STORE, 3'd2, 7'h00, 1'b0);
        ifc.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ifc.mem_ready = 1'b0;
        @(negedge clk);
        check("sw_memwrite_pending", ifc.MemWrite, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("sw_memwrite_reset_drop", ifc.MemWrite, 1'b0);
        ifc.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr(OP_R, 3'd7, 7'h00, 1'b0, 0, 0);      // restart from fetch

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 8) == 0) begin
                do op = 7'($urandom_range(0, 127)); while (valid_op(op));
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            run_instr(op, 3'($urandom_range(0, 7)), f7, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : 0,
                      $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : 0);
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
